mem_arbiter: RTL and testbench

- Shares one RV32I mock memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Issues at most one transaction at a time.
- Drives address, funct3 size select, write enable and write data into the memory's read/write port, then returns registered read data to the winning requester.
- Checks LS alignment and funct3 legality. Illegal accesses never reach memory.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RV32I mock memory port between instruction fetch (IF)
// and load/store (LS). One transaction at a time: IDLE -> ACCESS -> RESP.
// LS accesses are checked for funct3 legality and alignment; illegal ones skip
// memory and answer with an error response.
// Optional grant/error statistics counters: define MEM_ARBITER_STATS_EN.
module mem_arbiter #(
  parameter int MEM_LAT      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic        ls_we_i,
  input  logic [2:0]  ls_funct3_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  mem_sel_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
`ifdef MEM_ARBITER_STATS_EN
  output logic [31:0] stat_if_cnt_o,
  output logic [31:0] stat_ls_cnt_o,
  output logic [15:0] stat_err_cnt_o,
`endif
  input  logic [31:0] mem_rdata_i
);

  localparam int LAT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             state_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [2:0]         sel_q;
  logic               we_q;
  logic               ownerLs_q;
  logic               err_q;
  logic               ifRvalid_q;
  logic               lsRvalid_q;
  logic [LAT_W-1:0]   latCnt_q;
  logic [STV_W-1:0]   starveCnt_q;
  logic [STV_W-1:0]   starveCnt_d;
  logic               lsErr_d;
  logic               ifWins;
  logic               ifGnt;
  logic               lsGnt;
  logic               unusedIfAddr;

  // Fetches are always word aligned, so the low address bits carry no meaning.
  assign unusedIfAddr = ^if_addr_i[1:0];

  // Arbitration: LS wins ties unless IF has lost STARVE_LIMIT times in a row.
  always_comb begin
    ifWins = if_req_i && (!ls_req_i || (starveCnt_q == STV_W'(STARVE_LIMIT)));
    ifGnt  = (state_q == IDLE) && !rst && ifWins;
    lsGnt  = (state_q == IDLE) && !rst && ls_req_i && !ifWins;
  end

  // LS legality: reserved funct3, unsigned stores, and misaligned half/word.
  always_comb begin
    lsErr_d = 1'b1;
    case (ls_funct3_i)
      3'b000:  lsErr_d = 1'b0;
      3'b100:  lsErr_d = ls_we_i;
      3'b001:  lsErr_d = ls_addr_i[0];
      3'b101:  lsErr_d = ls_we_i || ls_addr_i[0];
      3'b010:  lsErr_d = (ls_addr_i[1:0] != 2'b00);
      default: lsErr_d = 1'b1;
    endcase
  end

  // Starvation counter: saturating count of IF losses, cleared by an IF grant.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (ifGnt) begin
      starveCnt_d = '0;
    end else if (lsGnt && if_req_i && (starveCnt_q != STV_W'(STARVE_LIMIT))) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  // Transaction FSM: latch the winner in IDLE, hold the memory port for
  // MEM_LAT+1 cycles in ACCESS, then give a single response pulse in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sel_q       <= 3'b010;
      we_q        <= 1'b0;
      ownerLs_q   <= 1'b0;
      err_q       <= 1'b0;
      ifRvalid_q  <= 1'b0;
      lsRvalid_q  <= 1'b0;
      latCnt_q    <= '0;
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      ifRvalid_q  <= 1'b0;
      lsRvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ifGnt) begin
            addr_q    <= {if_addr_i[31:2], 2'b00};
            sel_q     <= 3'b010;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ownerLs_q <= 1'b0;
            err_q     <= 1'b0;
            latCnt_q  <= LAT_W'(MEM_LAT);
            state_q   <= ACCESS;
          end else if (lsGnt) begin
            addr_q    <= ls_addr_i;
            sel_q     <= ls_funct3_i;
            we_q      <= ls_we_i && !lsErr_d;
            wdata_q   <= ls_wdata_i;
            ownerLs_q <= 1'b1;
            err_q     <= lsErr_d;
            rdata_q   <= '0;
            latCnt_q  <= LAT_W'(MEM_LAT);
            if (lsErr_d) begin
              lsRvalid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              state_q    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (latCnt_q == '0) begin
            rdata_q <= we_q ? 32'h0 : mem_rdata_i;
            state_q <= RESP;
            if (ownerLs_q) begin
              lsRvalid_q <= 1'b1;
            end else begin
              ifRvalid_q <= 1'b1;
            end
          end else begin
            latCnt_q <= latCnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt_o    = ifGnt;
  assign ls_gnt_o    = lsGnt;
  assign if_rvalid_o = ifRvalid_q;
  assign ls_rvalid_o = lsRvalid_q;
  assign if_rdata_o  = rdata_q;
  assign ls_rdata_o  = rdata_q;
  assign ls_err_o    = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sel_o   = (state_q == ACCESS) ? sel_q : 3'b010;
  assign mem_wen_o   = (state_q == ACCESS) && (latCnt_q == '0) && we_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] statIf_q;
  logic [31:0] statLs_q;
  logic [15:0] statErr_q;

  // Free-running, wrapping counts of grants and LS error responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statIf_q  <= '0;
      statLs_q  <= '0;
      statErr_q <= '0;
    end else begin
      if (ifGnt) begin
        statIf_q <= statIf_q + 1'b1;
      end
      if (lsGnt) begin
        statLs_q <= statLs_q + 1'b1;
      end
      if (lsGnt && lsErr_d) begin
        statErr_q <= statErr_q + 1'b1;
      end
    end
  end

  assign stat_if_cnt_o  = statIf_q;
  assign stat_ls_cnt_o  = statLs_q;
  assign stat_err_cnt_o = statErr_q;
`else
  // Statistics disabled: no counters or ports are built.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance "a" runs with
// MEM_LAT=0 against a small byte-addressable memory model; instance "b" runs
// with MEM_LAT=2 against an address-derived read pattern for the latency and
// reset-during-access cases.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a (MEM_LAT = 0)
  logic        aRst, aIfReq, aIfGnt, aIfRvalid;
  logic [31:0] aIfAddr, aIfRdata;
  logic        aLsReq, aLsWe, aLsGnt, aLsRvalid, aLsErr;
  logic [2:0]  aLsF3;
  logic [31:0] aLsAddr, aLsWdata, aLsRdata;
  logic [31:0] aMemAddr, aMemWdata, aMemRdata;
  logic [2:0]  aMemSel;
  logic        aMemWen;

  // Instance b (MEM_LAT = 2)
  logic        bRst, bIfReq, bIfGnt, bIfRvalid;
  logic [31:0] bIfAddr, bIfRdata;
  logic        bLsReq, bLsWe, bLsGnt, bLsRvalid, bLsErr;
  logic [2:0]  bLsF3;
  logic [31:0] bLsAddr, bLsWdata, bLsRdata;
  logic [31:0] bMemAddr, bMemWdata, bMemRdata;
  logic [2:0]  bMemSel;
  logic        bMemWen;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] aStatIf, aStatLs, bStatIf, bStatLs;
  logic [15:0] aStatErr, bStatErr;
`endif

  mem_arbiter #(.MEM_LAT(0), .STARVE_LIMIT(4)) dutA (
    .clk(clk), .rst(aRst),
    .if_req_i(aIfReq), .if_addr_i(aIfAddr), .if_gnt_o(aIfGnt),
    .if_rvalid_o(aIfRvalid), .if_rdata_o(aIfRdata),
    .ls_req_i(aLsReq), .ls_addr_i(aLsAddr), .ls_we_i(aLsWe),
    .ls_funct3_i(aLsF3), .ls_wdata_i(aLsWdata), .ls_gnt_o(aLsGnt),
    .ls_rvalid_o(aLsRvalid), .ls_rdata_o(aLsRdata), .ls_err_o(aLsErr),
    .mem_addr_o(aMemAddr), .mem_sel_o(aMemSel), .mem_wen_o(aMemWen),
    .mem_wdata_o(aMemWdata),
`ifdef MEM_ARBITER_STATS_EN
    .stat_if_cnt_o(aStatIf), .stat_ls_cnt_o(aStatLs), .stat_err_cnt_o(aStatErr),
`endif
    .mem_rdata_i(aMemRdata)
  );

  mem_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) dutB (
    .clk(clk), .rst(bRst),
    .if_req_i(bIfReq), .if_addr_i(bIfAddr), .if_gnt_o(bIfGnt),
    .if_rvalid_o(bIfRvalid), .if_rdata_o(bIfRdata),
    .ls_req_i(bLsReq), .ls_addr_i(bLsAddr), .ls_we_i(bLsWe),
    .ls_funct3_i(bLsF3), .ls_wdata_i(bLsWdata), .ls_gnt_o(bLsGnt),
    .ls_rvalid_o(bLsRvalid), .ls_rdata_o(bLsRdata), .ls_err_o(bLsErr),
    .mem_addr_o(bMemAddr), .mem_sel_o(bMemSel), .mem_wen_o(bMemWen),
    .mem_wdata_o(bMemWdata),
`ifdef MEM_ARBITER_STATS_EN
    .stat_if_cnt_o(bStatIf), .stat_ls_cnt_o(bStatLs), .stat_err_cnt_o(bStatErr),
`endif
    .mem_rdata_i(bMemRdata)
  );

  // Memory model for instance a: 64 words, sel-driven extension on reads.
  logic [31:0] memW [0:63];
  logic [31:0] memWord, memShift;

  always_comb begin
    memWord  = memW[aMemAddr[7:2]];
    memShift = memWord >> {aMemAddr[1:0], 3'b000};
    case (aMemSel)
      3'b000:  aMemRdata = {{24{memShift[7]}}, memShift[7:0]};
      3'b100:  aMemRdata = {24'h0, memShift[7:0]};
      3'b001:  aMemRdata = {{16{memShift[15]}}, memShift[15:0]};
      3'b101:  aMemRdata = {16'h0, memShift[15:0]};
      default: aMemRdata = memWord;
    endcase
  end

  // Memory writes; the reset window also reloads the preset contents.
  always @(posedge clk) begin
    if (aRst) begin
      for (int i = 0; i < 64; i++) memW[i] <= 32'h0;
      memW[2] <= 32'h0000_0013;
    end else if (aMemWen) begin
      case (aMemSel)
        3'b000:  memW[aMemAddr[7:2]][{aMemAddr[1:0], 3'b000} +: 8] <= aMemWdata[7:0];
        3'b001:  memW[aMemAddr[7:2]][{aMemAddr[1], 4'b0000} +: 16] <= aMemWdata[15:0];
        default: memW[aMemAddr[7:2]] <= aMemWdata;
      endcase
    end
  end

  // Instance b returns a pattern derived from the address.
  assign bMemRdata = bMemAddr ^ 32'hA5A5_0000;

  // Grant log, rvalid overlap and instance-b activity monitors.
  logic gntLog [$];
  int   gntCyc [$];
  int   cycle = 0;
  int   overlap = 0;
  int   bWen = 0;
  int   bRvalid = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (aIfGnt) begin
      gntLog.push_back(1'b0);
      gntCyc.push_back(cycle);
    end
    if (aLsGnt) begin
      gntLog.push_back(1'b1);
      gntCyc.push_back(cycle);
    end
    if (aIfRvalid && aLsRvalid) overlap <= overlap + 1;
    if (bMemWen) bWen <= bWen + 1;
    if (bLsRvalid) bRvalid <= bRvalid + 1;
  end

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One transaction on instance a; reports data, error, grant-to-rvalid
  // latency, write pulses and the port state in the first post-grant cycle.
  task automatic applyStimulus(input logic isLs, input logic [31:0] addr,
                               input logic we, input logic [2:0] f3,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int wenCnt,
                               output logic [2:0] wenSel,
                               output logic [2:0] accSel,
                               output logic [31:0] accAddr);
    logic got;
    logic rv;
    got = 1'b0; lat = -1; wenCnt = 0; wenSel = 3'b111;
    accSel = 3'b111; accAddr = 32'hFFFF_FFFF; rdata = 32'hFFFF_FFFF; err = 1'b0;
    @(negedge clk);
    if (isLs) begin
      aLsReq = 1'b1; aLsAddr = addr; aLsWe = we; aLsF3 = f3; aLsWdata = wdata;
    end else begin
      aIfReq = 1'b1; aIfAddr = addr;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if ((isLs && aLsGnt) || (!isLs && aIfGnt)) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput("gntTimeout", 32'd0, 32'd1);
      aLsReq = 1'b0; aIfReq = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      aLsReq = 1'b0; aIfReq = 1'b0;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(negedge clk);
        if (k == 1) begin
          accSel = aMemSel; accAddr = aMemAddr;
        end
        if (aMemWen) begin
          wenCnt++; wenSel = aMemSel;
        end
        rv = isLs ? aLsRvalid : aIfRvalid;
        if (rv) begin
          lat = k;
          rdata = isLs ? aLsRdata : aIfRdata;
          err = aLsErr;
        end
      end
    end
  endtask

  // One LS transaction on instance b.
  task automatic bTransaction(input logic [31:0] addr, input logic we,
                              input logic [2:0] f3, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err,
                              output int lat);
    logic got;
    got = 1'b0; lat = -1; rdata = 32'hFFFF_FFFF; err = 1'b0;
    @(negedge clk);
    bLsReq = 1'b1; bLsAddr = addr; bLsWe = we; bLsF3 = f3; bLsWdata = wdata;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (bLsGnt) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput("bGntTimeout", 32'd0, 32'd1);
      bLsReq = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bLsReq = 1'b0;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(negedge clk);
        if (bLsRvalid) begin
          lat = k; rdata = bLsRdata; err = bLsErr;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] rd;
  logic        er;
  int          lt, wc, s, bWen0, bRv0;
  logic [2:0]  ws, as;
  logic [31:0] aa;
  logic [9:0]  obsPat;

  initial begin
    aRst = 1'b1; bRst = 1'b1;
    aIfReq = 1'b1; aIfAddr = 32'h8;
    aLsReq = 1'b1; aLsAddr = 32'h0; aLsWe = 1'b0; aLsF3 = 3'b010; aLsWdata = 32'h0;
    bIfReq = 1'b0; bIfAddr = 32'h0;
    bLsReq = 1'b0; bLsAddr = 32'h0; bLsWe = 1'b0; bLsF3 = 3'b010; bLsWdata = 32'h0;

    // Reset values, with both requests held to show grants stay low.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstIfGnt", {31'b0, aIfGnt}, 32'd0);
    checkOutput("rstLsGnt", {31'b0, aLsGnt}, 32'd0);
    checkOutput("rstMemSel", {29'b0, aMemSel}, 32'd2);
    checkOutput("rstMemWen", {31'b0, aMemWen}, 32'd0);
    checkOutput("rstMemAddr", aMemAddr, 32'd0);
    checkOutput("rstLsRdata", aLsRdata, 32'd0);
    aIfReq = 1'b0; aLsReq = 1'b0;
    @(negedge clk);
    aRst = 1'b0; bRst = 1'b0;

    // Fetch path.
    applyStimulus(1'b0, 32'h8, 1'b0, 3'b010, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("fetchData", rd, 32'h0000_0013);
    checkOutput("fetchLat", lt, 32'd2);
    checkOutput("fetchSel", {29'b0, as}, 32'd2);
    checkOutput("fetchAddr", aa, 32'h8);
    @(negedge clk);
    checkOutput("fetchRvalidOnce", {31'b0, aIfRvalid}, 32'd0);
    applyStimulus(1'b0, 32'hB, 1'b0, 3'b010, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("fetchMaskData", rd, 32'h0000_0013);
    checkOutput("fetchMaskAddr", aa, 32'h8);

    // Simultaneous requests: LS first, IF in the IDLE cycle after LS RESP.
    @(negedge clk);
    s = gntLog.size();
    aIfReq = 1'b1; aIfAddr = 32'h8;
    aLsReq = 1'b1; aLsAddr = 32'h10; aLsWe = 1'b0; aLsF3 = 3'b010;
    for (int n = 0; n < 30 && gntLog.size() < s + 2; n++) begin
      @(negedge clk);
      for (int j = s; j < gntLog.size(); j++) begin
        if (gntLog[j]) aLsReq = 1'b0;
        else aIfReq = 1'b0;
      end
    end
    aIfReq = 1'b0; aLsReq = 1'b0;
    if (gntLog.size() < s + 2) begin
      checkOutput("simulGrants", gntLog.size() - s, 32'd2);
    end else begin
      checkOutput("simulFirstLs", {31'b0, gntLog[s]}, 32'd1);
      checkOutput("simulSecondIf", {31'b0, gntLog[s+1]}, 32'd0);
      checkOutput("simulSpacing", gntCyc[s+1] - gntCyc[s], 32'd3);
    end
    repeat (4) @(negedge clk);

    // Starvation: both requesting continuously.
    s = gntLog.size();
    aIfReq = 1'b1; aIfAddr = 32'h8;
    aLsReq = 1'b1; aLsAddr = 32'h10; aLsWe = 1'b0; aLsF3 = 3'b010;
    for (int n = 0; n < 60 && gntLog.size() < s + 10; n++) @(negedge clk);
    aIfReq = 1'b0; aLsReq = 1'b0;
    obsPat = '0;
    for (int j = 0; j < 10; j++) begin
      if (s + j < gntLog.size()) obsPat[9-j] = gntLog[s+j];
    end
    checkOutput("starvePattern", {22'b0, obsPat}, {22'b0, 10'b1111011110});
    repeat (6) @(negedge clk);
    checkOutput("rvalidOverlap", overlap, 32'd0);

    // Error responses: never reach memory, one cycle after grant.
    applyStimulus(1'b1, 32'h21, 1'b0, 3'b001, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("lhMisErr", {31'b0, er}, 32'd1);
    checkOutput("lhMisData", rd, 32'd0);
    checkOutput("lhMisLat", lt, 32'd1);
    checkOutput("lhMisWen", wc, 32'd0);
    applyStimulus(1'b1, 32'h22, 1'b1, 3'b010, 32'h1234_5678, rd, er, lt, wc, ws, as, aa);
    checkOutput("swMisErr", {31'b0, er}, 32'd1);
    checkOutput("swMisLat", lt, 32'd1);
    checkOutput("swMisWen", wc, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b0, 3'b011, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("f3IllegalErr", {31'b0, er}, 32'd1);
    checkOutput("f3IllegalLat", lt, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b1, 3'b100, 32'h55, rd, er, lt, wc, ws, as, aa);
    checkOutput("storeUnsErr", {31'b0, er}, 32'd1);
    checkOutput("storeUnsWen", wc, 32'd0);

    // Store then loads.
    applyStimulus(1'b1, 32'h40, 1'b1, 3'b000, 32'h1234_56AB, rd, er, lt, wc, ws, as, aa);
    checkOutput("sbWenCount", wc, 32'd1);
    checkOutput("sbWenSel", {29'b0, ws}, 32'd0);
    checkOutput("sbErr", {31'b0, er}, 32'd0);
    checkOutput("sbData", rd, 32'd0);
    checkOutput("sbLat", lt, 32'd2);
    applyStimulus(1'b1, 32'h40, 1'b0, 3'b100, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("lbuData", rd, 32'h0000_00AB);
    checkOutput("lbuWen", wc, 32'd0);
    applyStimulus(1'b1, 32'h40, 1'b0, 3'b000, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("lbData", rd, 32'hFFFF_FFAB);
    applyStimulus(1'b1, 32'h42, 1'b1, 3'b001, 32'h0000_BEEF, rd, er, lt, wc, ws, as, aa);
    checkOutput("shWenSel", {29'b0, ws}, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 3'b010, 32'h0, rd, er, lt, wc, ws, as, aa);
    checkOutput("lwData", rd, 32'hBEEF_00AB);

    // Reset during the first ACCESS cycle of a store (MEM_LAT = 2).
    bWen0 = bWen; bRv0 = bRvalid;
    @(negedge clk);
    bLsReq = 1'b1; bLsAddr = 32'h44; bLsWe = 1'b1; bLsF3 = 3'b010; bLsWdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("bGnt", {31'b0, bLsGnt}, 32'd1);
    @(posedge clk);
    #1;
    bLsReq = 1'b0;
    bRst = 1'b1;
    #1;
    checkOutput("bRstMemWen", {31'b0, bMemWen}, 32'd0);
    checkOutput("bRstMemSel", {29'b0, bMemSel}, 32'd2);
    checkOutput("bRstMemAddr", bMemAddr, 32'd0);
    checkOutput("bRstRvalid", {31'b0, bLsRvalid}, 32'd0);
    repeat (2) @(negedge clk);
    bRst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("bNoWenAfterRst", bWen - bWen0, 32'd0);
    checkOutput("bNoRvalidAfterRst", bRvalid - bRv0, 32'd0);
    bTransaction(32'h48, 1'b0, 3'b010, 32'h0, rd, er, lt);
    checkOutput("bLoadData", rd, 32'hA5A5_0048);
    checkOutput("bLoadLat", lt, 32'd4);
    checkOutput("bLoadErr", {31'b0, er}, 32'd0);
    bWen0 = bWen;
    bTransaction(32'h4C, 1'b1, 3'b010, 32'h0BAD_F00D, rd, er, lt);
    checkOutput("bStoreLat", lt, 32'd4);
    @(negedge clk);
    checkOutput("bStoreWenCount", bWen - bWen0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
